// File: rtl/uart_msg_sender.sv
// uart_msg_sender: buffered UART message transmitter with single-shot, repeat and graceful abort.
// Define UART_MSG_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_msg_sender #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int BAUD_DIV = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   msg_len,
  input  logic              start,
  input  logic              repeat_en,
  input  logic              abort,
  output logic              uart_tx,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   char_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int BW    = $clog2(BAUD_DIV);
  localparam int IW    = DATA_W > 1 ? $clog2(DATA_W) : 1;
`ifdef UART_MSG_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_DONE} state_t;
  localparam state_t S_AFTER_DATA = S_STOP;
`endif
  state_t state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [BW-1:0] baud_q, baud_d;
  logic [IW-1:0] bit_q, bit_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0] cnt_q, cnt_d, len_q, len_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic abort_q, abort_d, tx_q, tx_d, last_baud;
  assign last_baud = baud_q == BW'(BAUD_DIV - 1);
  assign uart_tx = tx_q;
  assign char_cnt = cnt_q;
  // Buffer has no reset; a write racing S_LOAD on the same entry lands after the read.
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_addr] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    len_d = len_q;
    data_d = data_q;
    bit_d = bit_q;
    abort_d = abort_q | (abort & (state_q != S_IDLE));
    case (state_q)
      S_IDLE: if (start && msg_len != '0) begin
        state_d = S_LOAD;
        len_d = msg_len > (ADDR_W+1)'(DEPTH) ? (ADDR_W+1)'(DEPTH) : msg_len;
        idx_d = '0;
        cnt_d = '0;
        abort_d = 1'b0;
      end
      S_LOAD: begin
        data_d = mem_q[idx_q];
        state_d = S_START;
      end
      S_START: if (last_baud) state_d = S_DATA;
      S_DATA: if (last_baud) begin
        bit_d = bit_q == IW'(DATA_W - 1) ? '0 : bit_q + IW'(1);
        if (bit_q == IW'(DATA_W - 1)) state_d = S_AFTER_DATA;
      end
`ifdef UART_MSG_PARITY_EN
      S_PARITY: if (last_baud) state_d = S_STOP;
`endif
      S_STOP: if (last_baud) begin
        cnt_d = cnt_q + (ADDR_W+1)'(1);
        if (abort_d) state_d = S_DONE;
        else if ((ADDR_W+1)'(idx_q) + (ADDR_W+1)'(1) < len_q) begin
          idx_d = idx_q + ADDR_W'(1);
          state_d = S_LOAD;
        end else if (repeat_en) begin
          idx_d = '0;
          cnt_d = '0;
          state_d = S_LOAD;
        end else state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    baud_d = (state_d != state_q || last_baud) ? '0 : baud_q + BW'(1);
  end
  always_comb begin
    busy = state_q != S_IDLE;
    done = state_q == S_DONE;
`ifdef UART_MSG_PARITY_EN
    tx_d = state_q == S_PARITY ? ^data_q : 1'b1;
`else
    tx_d = 1'b1;
`endif
    tx_d = state_q == S_START ? 1'b0 : state_q == S_DATA ? data_q[bit_q] : tx_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      baud_q <= '0;
      bit_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      data_q <= '0;
      abort_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      baud_q <= baud_d;
      bit_q <= bit_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      data_q <= data_d;
      abort_q <= abort_d;
      tx_q <= tx_d;
    end
endmodule

// File: tb/tb_uart_msg_sender.sv
// tb_uart_msg_sender: line-level UART receiver model checks frames, timing and control of uart_msg_sender.
module tb_uart_msg_sender;
`ifdef UART_MSG_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 10 + PAR;
  localparam int CHAR_CYC = 1 + NB * 4;
  logic clk = 0, rst = 1, wr_en = 0, start = 0, repeat_en = 0, abort = 0;
  logic [1:0] wr_addr = 0;
  logic [7:0] wr_data = 0;
  logic [2:0] msg_len = 0;
  logic uart_tx, busy, done;
  logic [2:0] char_cnt;
  int checks = 0, errors = 0, done_cnt = 0, k = -1, frame_err = 0;
  logic [7:0] mem [4];
  logic [7:0] rx_q[$];
  logic par_q[$];
  logic [NB-1:0] fr;

  uart_msg_sender #(.DATA_W(8), .ADDR_W(2), .BAUD_DIV(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start), .repeat_en(repeat_en), .abort(abort),
    .uart_tx(uart_tx), .busy(busy), .done(done), .char_cnt(char_cnt));

  always #5 clk = ~clk;

  // k counts cycles from the first low line cycle; bit j is sampled mid-bit at k = 4j+2
  always @(negedge clk) begin
    if (rst) k = -1;
    else if (k < 0) begin
      if (!uart_tx) k = 0;
    end else begin
      k++;
      if (k % 4 == 2) fr[k/4] = uart_tx;
      if (k == 4 * (NB - 1) + 2) begin
        rx_q.push_back(fr[8:1]);
`ifdef UART_MSG_PARITY_EN
        par_q.push_back(fr[9]);
`endif
        if (fr[0] || !fr[NB-1]) frame_err++;
        k = -1;
      end
    end
  end

  always @(negedge clk) if (!rst && done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en = 1; wr_addr = 2'(a); wr_data = d; mem[a] = d;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic wait_done(input int maxc, output int lat, output logic b1, output logic t2,
                           output logic t3, output logic [2:0] cc);
    lat = 0; b1 = 0; t2 = 0; t3 = 0;
    do begin
      @(posedge clk); #1;
      start = 0;
      lat++;
      if (lat == 1) b1 = busy;
      if (lat == 2) t2 = uart_tx;
      if (lat == 3) t3 = uart_tx;
    end while (!done && lat < maxc);
    if (!done) chk("done_timeout", 0, 1);
    cc = char_cnt;
  endtask

  task automatic wait_rx(input int nfr, input int kmin, input string tag);
    int n = 0;
    while (!(rx_q.size() >= nfr && k >= kmin) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_rx(input string tag, input logic [7:0] e[$]);
    chk({tag, "_frames"}, rx_q.size(), e.size());
    foreach (e[i]) begin
      chk($sformatf("%s_byte%0d", tag, i), i < rx_q.size() ? 32'(rx_q[i]) : 32'hDEAD, 32'(e[i]));
`ifdef UART_MSG_PARITY_EN
      chk($sformatf("%s_par%0d", tag, i), i < par_q.size() ? 32'(par_q[i]) : 32'hDEAD, 32'(^e[i]));
`endif
    end
    chk({tag, "_framing"}, frame_err, 0);
    rx_q.delete();
    par_q.delete();
  endtask

  initial begin
    int lat, d0, n;
    logic b1, t2, t3, saw_busy, saw_low;
    logic [2:0] cc;
    logic [7:0] e[$];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", uart_tx, 1); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_cnt", char_cnt, 0);
    rst = 0;
    @(posedge clk); #1;

    // four-character single shot
    wr(0, 8'h41); wr(1, 8'h55); wr(2, 8'h66); wr(3, 8'h7A);
    d0 = done_cnt; msg_len = 4; start = 1;
    wait_done(1000, lat, b1, t2, t3, cc);
    chk("s1_busy_after_start", b1, 1); chk("s1_tx_before_start", t2, 1);
    chk("s1_start_bit", t3, 0); chk("s1_done_lat", lat, 1 + 4 * CHAR_CYC);
    chk("s1_char_cnt", cc, 4);
    repeat (4) @(posedge clk); #1;
    chk("s1_done_once", done_cnt - d0, 1); chk("s1_idle", busy, 0);
    e.delete(); e.push_back(8'h41); e.push_back(8'h55); e.push_back(8'h66); e.push_back(8'h7A);
    check_rx("s1", e);

    // zero length is ignored
    msg_len = 0; start = 1; d0 = done_cnt; saw_busy = 0; saw_low = 0;
    repeat (10) begin
      @(posedge clk); #1;
      saw_busy |= busy; saw_low |= !uart_tx;
    end
    start = 0;
    chk("len0_busy", saw_busy, 0); chk("len0_tx", saw_low, 0); chk("len0_done", done_cnt - d0, 0);

    // repeat mode, abort during the third frame
    msg_len = 2; repeat_en = 1; start = 1; d0 = done_cnt;
    @(posedge clk); #1; start = 0;
    wait_rx(2, 10, "s3");
    abort = 1;
    @(posedge clk); #1; abort = 0;
    wait_done(500, lat, b1, t2, t3, cc);
    repeat_en = 0;
    chk("s3_char_cnt", cc, 1);
    repeat (60) @(posedge clk); #1;
    chk("s3_done_once", done_cnt - d0, 1); chk("s3_idle", busy, 0);
    e.delete(); e.push_back(8'h41); e.push_back(8'h55); e.push_back(8'h41);
    check_rx("s3", e);

    // rewrite buf[1] during frame 0, extra start while busy
    msg_len = 2; start = 1; d0 = done_cnt;
    @(posedge clk); #1; start = 0;
    wait_rx(0, 10, "s5");
    wr(1, 8'h30);
    start = 1;
    @(posedge clk); #1; start = 0;
    wait_done(500, lat, b1, t2, t3, cc);
    chk("s5_char_cnt", cc, 2);
    repeat (60) @(posedge clk); #1;
    chk("s5_done_once", done_cnt - d0, 1); chk("s5_idle", busy, 0);
    e.delete(); e.push_back(8'h41); e.push_back(8'h30);
    check_rx("s5", e);

    // async reset during the second data bit
    msg_len = 1; start = 1;
    @(posedge clk); #1; start = 0;
    wait_rx(0, 9, "s4");
    chk("s4_line_low", uart_tx, 0);
    #2 rst = 1;
    #1;
    chk("s4_rst_tx", uart_tx, 1); chk("s4_rst_busy", busy, 0);
    @(negedge clk);
    @(posedge clk); #1; rst = 0;
    rx_q.delete(); par_q.delete();
    msg_len = 1; start = 1;
    wait_done(500, lat, b1, t2, t3, cc);
    chk("s4_lat", lat, 1 + CHAR_CYC);
    repeat (4) @(posedge clk); #1;
    e.delete(); e.push_back(8'h41);
    check_rx("s4", e);

    // random contents and lengths, including lengths past the buffer depth
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < 4; a++) wr(a, 8'($urandom));
      msg_len = 3'($urandom_range(1, 7));
      n = msg_len > 4 ? 4 : int'(msg_len);
      d0 = done_cnt; start = 1;
      wait_done(1000, lat, b1, t2, t3, cc);
      chk($sformatf("r%0d_lat", it), lat, 1 + n * CHAR_CYC);
      chk($sformatf("r%0d_cnt", it), cc, n);
      repeat (4) @(posedge clk); #1;
      chk($sformatf("r%0d_done", it), done_cnt - d0, 1);
      e.delete();
      for (int i = 0; i < n; i++) e.push_back(mem[i]);
      check_rx($sformatf("r%0d", it), e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_msg_sender.md
# uart_msg_sender

Parametrised UART message transmitter with a built-in serializer. It holds a writable message buffer of up to 2**ADDR_W characters and sends the first msg_len entries as 8N1-style frames on start. It supports single-shot and continuous repeat modes, plus a graceful abort. It sits between board-level control logic (buttons, switches, a host register port) and the UART_TXD pin, and replaces hand-coded per-board message testers.

## Interface
- DATA_W, 8: data bits per character.
- ADDR_W, 4: buffer address width; DEPTH = 2**ADDR_W entries.
- BAUD_DIV, 868: clk cycles per serial bit, ≥ 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe for the message buffer.
- wr_addr  in  ADDR_W  buffer write address.
- wr_data  in  DATA_W  buffer write data.
- msg_len  in  ADDR_W+1  characters per pass; latched on start.
- start  in  1  level, sampled only in S_IDLE.
- repeat_en  in  1  continuous mode; sampled at the end of each pass.
- abort  in  1  request to stop after the current character.
- uart_tx  out  1  serial line, idle high, registered.
- busy  out  1  high in every state except S_IDLE.
- done  out  1  one-cycle pulse at the end of a message.
- char_cnt  out  ADDR_W+1  characters completed in the current pass.

## Operation
- States: S_IDLE, S_LOAD, S_START, S_DATA, (S_PARITY), S_STOP, S_DONE.
- S_IDLE:
  - If start=1 and msg_len≠0: latch len = min(msg_len, DEPTH), idx=0, char_cnt=0, clear abort flag, go to S_LOAD.
  - msg_len=0: start is ignored.
- S_LOAD: shift register ← buf[idx]; go to S_START.
- S_START: uart_tx=0 for BAUD_DIV cycles.
- S_DATA: DATA_W bits, LSB first, BAUD_DIV cycles each.
- S_STOP: uart_tx=1 for BAUD_DIV cycles. At the end, char_cnt+1, then:
  - Abort flag set: go to S_DONE.
  - Else if idx+1 < len: idx+1, go to S_LOAD.
  - Else if repeat_en=1: idx=0, char_cnt=0, go to S_LOAD.
  - Else: go to S_DONE.
- S_DONE: done=1 for one cycle; go to S_IDLE.
- Abort: abort=1 in any busy cycle sets a sticky flag. The current frame always completes. The flag is cleared on the next start.
- Buffer writes:
  - Accepted in every state.
  - A write to buf[idx] in the same cycle as S_LOAD loads the old value.
  - Buffer contents are not reset.
- start asserted while busy is ignored. A start held high retriggers one cycle after S_DONE.
- Baud counter: counts 0..BAUD_DIV-1 and restarts at every state change. The bit counter wraps at DATA_W.

## Timing
- Reset values: uart_tx=1, busy=0, done=0, char_cnt=0, state S_IDLE, counters 0. uart_tx goes high asynchronously on rst.
- start sampled high at edge n: busy=1 after edge n, uart_tx=0 after edge n+2.
- Per-character cost: 1 + (DATA_W+2)·BAUD_DIV cycles, or +BAUD_DIV with parity.
- done asserts one cycle after the last stop bit ends. busy falls in the same cycle as done deasserts.
- rst mid-frame: immediate return to idle line. No partial frame resumes.

## Configuration
- UART_MSG_PARITY_EN:
  - Defined: S_PARITY is inserted after S_DATA and drives the even-parity bit (XOR of data bits) for BAUD_DIV cycles.
  - Undefined: no S_PARITY state; frame is start + DATA_W + stop.

## Test plan
- Settings for all scenarios: DATA_W=8, ADDR_W=2, BAUD_DIV=4.
- Write 41,55,66,7A; msg_len=4; pulse start.
  - Four frames are sent; the first data bits read 1,0,0,0,0,0,1,0.
  - done pulses exactly once, 1+4·41 cycles after start is sampled; char_cnt=4.
- msg_len=0, start=1 for 10 cycles: busy stays 0, uart_tx stays 1, no done.
- repeat_en=1, msg_len=2 with 41,55 loaded:
  - Line carries 41,55,41.
  - Pulse abort during the third frame's data: that frame completes with its stop bit, done pulses, no further start bit.
- rst pulse during the second data bit: uart_tx=1 and busy=0 in the same cycle. The next start sends buf[0] from the beginning.
- Write buf[1]=0x30 during frame 0 with msg_len=2: the second frame carries 0x30. A start pulse during transmission has no effect.
- With UART_MSG_PARITY_EN defined, send 0x41: parity bit 0, frame is 11 bits (44 cycles). Send 0x43: parity bit 1.
